fpnew_special_classify: RTL and testbench

Pipelined FP64 operand classifier. It decodes a 65-bit tagged word ({box bit, FP64}) into a RISC-V-style class mask, plus a canonical-NaN flag and a sticky invalid (NV) status. It is the receiving end of the special-result encoding produced by the FMA special-case path, and sits between the FMA result bus and downstream consumers (fclass, exception collection, debug).

---
 rtl/fpnew_special_classify_if.sv | 45 ++++
 rtl/fpnew_special_classify.sv | 129 ++++++++++++
 tb/tb_fpnew_special_classify.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fpnew_special_classify_if.sv
`default_nettype none
// ==========================================================================
// fpnew_special_classify_if : operand/result handshake bundle (rev 1.0)
// ==========================================================================
interface fpnew_special_classify_if;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [64:0] operand_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [9:0]  class_o;
  logic        sign_o;
  logic        is_special_o;
  logic        is_canon_nan_o;
  logic        clr_status_i;
  logic        status_nv_o;
`ifdef FPNEW_CLASSIFY_STATS_EN
  logic [15:0] nan_count_o;
  logic [15:0] inf_count_o;

  modport slave (
    input  flush_i, in_valid_i, operand_i, out_ready_i, clr_status_i,
    output in_ready_o, out_valid_o, class_o, sign_o, is_special_o,
           is_canon_nan_o, status_nv_o, nan_count_o, inf_count_o
  );
  modport master (
    output flush_i, in_valid_i, operand_i, out_ready_i, clr_status_i,
    input  in_ready_o, out_valid_o, class_o, sign_o, is_special_o,
           is_canon_nan_o, status_nv_o, nan_count_o, inf_count_o
  );
`else
  modport slave (
    input  flush_i, in_valid_i, operand_i, out_ready_i, clr_status_i,
    output in_ready_o, out_valid_o, class_o, sign_o, is_special_o,
           is_canon_nan_o, status_nv_o
  );
  modport master (
    output flush_i, in_valid_i, operand_i, out_ready_i, clr_status_i,
    input  in_ready_o, out_valid_o, class_o, sign_o, is_special_o,
           is_canon_nan_o, status_nv_o
  );
`endif
endinterface
`default_nettype wire

// File: rtl/fpnew_special_classify.sv
`default_nettype none
// ==========================================================================
// fpnew_special_classify : elastic-pipelined FP64 class/NaN/NV decoder
// Option FPNEW_CLASSIFY_STATS_EN adds saturating NaN/Inf pop counters.
// Revision: 1.0
// ==========================================================================
module fpnew_special_classify #(
  parameter int NUM_STAGES = 2
) (
  input wire                      clk_i,
  input wire                      rst_i,
  fpnew_special_classify_if.slave bus
);

  localparam int          c_payload_w = 13;
  localparam logic [63:0] c_canon_nan = 64'h7FF8_0000_0000_0000;

  // Unboxed operands are reinterpreted as the canonical NaN before decoding
  logic [63:0]            w_val;
  logic                   w_sign;
  logic                   w_exp_ones;
  logic                   w_exp_zero;
  logic                   w_man_zero;
  logic [9:0]             w_class;
  logic [c_payload_w-1:0] w_payload;
  logic                   w_push;
  logic                   w_pop;

  assign w_val      = bus.operand_i[64] ? bus.operand_i[63:0] : c_canon_nan;
  assign w_sign     = w_val[63];
  assign w_exp_ones = &w_val[62:52];
  assign w_exp_zero = ~|w_val[62:52];
  assign w_man_zero = ~|w_val[51:0];

  always_comb begin
    w_class = '0;
    if (w_exp_ones) begin
      if (w_man_zero)      w_class[w_sign ? 0 : 7] = 1'b1;
      else if (w_val[51])  w_class[9] = 1'b1;
      else                 w_class[8] = 1'b1;
    end else if (w_exp_zero) begin
      if (w_man_zero)      w_class[w_sign ? 3 : 4] = 1'b1;
      else                 w_class[w_sign ? 2 : 5] = 1'b1;
    end else begin
      w_class[w_sign ? 1 : 6] = 1'b1;
    end
  end

  assign w_payload = {(w_val == c_canon_nan),
                      (w_class[0] | w_class[7] | w_class[8] | w_class[9]),
                      w_sign, w_class};

  logic [NUM_STAGES-1:0]  r_valid;
  logic [c_payload_w-1:0] r_data [NUM_STAGES];
  logic [NUM_STAGES-1:0]  w_accept;

  // A stage can take data if anything downstream of it (inclusive) has a hole
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_accept
    assign w_accept[k] = bus.out_ready_i | ~&r_valid[NUM_STAGES-1:k];
  end

  assign w_push = bus.in_valid_i & w_accept[0] & ~bus.flush_i;
  assign w_pop  = r_valid[NUM_STAGES-1] & bus.out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= '0;
      for (int k = 0; k < NUM_STAGES; k++) r_data[k] <= '0;
    end else begin
      if (w_accept[0]) r_valid[0] <= w_push;
      if (w_push)      r_data[0]  <= w_payload;
      for (int k = 1; k < NUM_STAGES; k++) begin
        if (w_accept[k]) begin
          r_valid[k] <= r_valid[k-1];
          if (r_valid[k-1]) r_data[k] <= r_data[k-1];
        end
      end
      if (bus.flush_i) r_valid <= '0;
    end
  end

  assign bus.in_ready_o     = w_accept[0];
  assign bus.out_valid_o    = r_valid[NUM_STAGES-1];
  assign bus.class_o        = r_data[NUM_STAGES-1][9:0];
  assign bus.sign_o         = r_data[NUM_STAGES-1][10];
  assign bus.is_special_o   = r_data[NUM_STAGES-1][11];
  assign bus.is_canon_nan_o = r_data[NUM_STAGES-1][12];

  logic r_status_nv;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                        r_status_nv <= 1'b0;
    else if (w_push && w_class[8])    r_status_nv <= 1'b1;
    else if (bus.clr_status_i)        r_status_nv <= 1'b0;
  end

  assign bus.status_nv_o = r_status_nv;

`ifdef FPNEW_CLASSIFY_STATS_EN
  logic [15:0] r_nan_count;
  logic [15:0] r_inf_count;
  logic        w_pop_nan;
  logic        w_pop_inf;

  assign w_pop_nan = w_pop & (bus.class_o[8] | bus.class_o[9]);
  assign w_pop_inf = w_pop & (bus.class_o[0] | bus.class_o[7]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_nan_count <= '0;
      r_inf_count <= '0;
    end else if (bus.clr_status_i) begin
      r_nan_count <= '0;
      r_inf_count <= '0;
    end else begin
      if (w_pop_nan && r_nan_count != 16'hFFFF) r_nan_count <= r_nan_count + 16'd1;
      if (w_pop_inf && r_inf_count != 16'hFFFF) r_inf_count <= r_inf_count + 16'd1;
    end
  end

  assign bus.nan_count_o = r_nan_count;
  assign bus.inf_count_o = r_inf_count;
`else
  logic w_unused_pop;
  assign w_unused_pop = w_pop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpnew_special_classify.sv
`default_nettype none
// Randomised and directed check of fpnew_special_classify against a
// field-arithmetic reference model with a FIFO scoreboard.
module tb_fpnew_special_classify;

  localparam int          C_NS    = 2;
  localparam logic [63:0] C_CANON = 64'h7FF8_0000_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpnew_special_classify_if bus ();

  fpnew_special_classify #(.NUM_STAGES(C_NS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pops   = 0;
  int accepts = 0;
  bit lat_en = 1'b0;
  bit held   = 1'b0;
  logic [13:0] held_snap = '0;
  logic [12:0] exp_q[$];
  int          pc_q[$];
  logic [9:0]  seen[$];
  logic [12:0] last_out = '0;
  bit          nv_m = 1'b0;
  logic [15:0] nan_m = '0;
  logic [15:0] inf_m = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Class derived from the numeric fields with plain arithmetic
  function automatic logic [12:0] ref_model(input logic [64:0] op);
    longint unsigned v, m;
    int unsigned e;
    bit neg, quiet;
    int idx;
    v     = op[64] ? op[63:0] : C_CANON;
    neg   = (v >= 64'h8000_0000_0000_0000);
    e     = 32'((v / (64'd1 << 52)) % 64'd2048);
    m     = v % (64'd1 << 52);
    quiet = (m >= (64'd1 << 51));
    if (e == 2047)   idx = (m == 0) ? (neg ? 0 : 7) : (quiet ? 9 : 8);
    else if (e == 0) idx = (m == 0) ? (neg ? 3 : 4) : (neg ? 2 : 5);
    else             idx = neg ? 1 : 6;
    return {(v == C_CANON), (idx == 0 || idx == 7 || idx >= 8), neg, 10'(1) << idx};
  endfunction

  function automatic logic [64:0] rand_op();
    logic        s;
    logic [51:0] m;
    logic [10:0] e;
    s = 1'($urandom);
    m = {20'($urandom), $urandom};
    e = 11'($urandom_range(1, 2046));
    case ($urandom_range(0, 7))
      0: return {1'b1, s, 11'd0, 52'd0};
      1: return {1'b1, s, 11'd0, (m == 0) ? 52'd1 : m};
      2: return {1'b1, s, e, m};
      3: return {1'b1, s, 11'h7FF, 52'd0};
      4: return {1'b1, s, 11'h7FF, 1'b1, m[50:0]};
      5: return {1'b1, s, 11'h7FF, 1'b0, (m[50:0] == 0) ? 51'd1 : m[50:0]};
      6: return {1'b0, $urandom, $urandom};
      default: return {1'b1, C_CANON};
    endcase
  endfunction

  task automatic tick();
    logic [13:0] snap;
    logic [12:0] p;
    bit in_fire, out_fire;
    @(negedge clk);
    cyc++;
    snap = {bus.out_valid_o, bus.is_canon_nan_o, bus.is_special_o, bus.sign_o, bus.class_o};
    if (held) chk("hold_stable", snap, held_snap);
    chk("status_nv", bus.status_nv_o, nv_m);
`ifdef FPNEW_CLASSIFY_STATS_EN
    chk("nan_count", bus.nan_count_o, nan_m);
    chk("inf_count", bus.inf_count_o, inf_m);
`endif
    out_fire = bus.out_valid_o && bus.out_ready_i;
    in_fire  = bus.in_valid_i && bus.in_ready_o && !bus.flush_i;
    if (bus.out_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("out_valid_unexpected", bus.out_valid_o, 0);
      end else begin
        chk("payload", snap[12:0], exp_q[0]);
        if (out_fire) begin
          if (lat_en) chk("latency", cyc - pc_q[0], C_NS);
          if (!bus.clr_status_i) begin
            if ((exp_q[0][9] || exp_q[0][8]) && nan_m != 16'hFFFF) nan_m++;
            if ((exp_q[0][0] || exp_q[0][7]) && inf_m != 16'hFFFF) inf_m++;
          end
          void'(exp_q.pop_front());
          void'(pc_q.pop_front());
          seen.push_back(bus.class_o);
          last_out = snap[12:0];
          pops++;
        end
      end
    end
    if (bus.clr_status_i) begin nan_m = '0; inf_m = '0; end
    held      = bus.out_valid_o && !bus.out_ready_i && !bus.flush_i;
    held_snap = snap;
    if (bus.flush_i) begin exp_q.delete(); pc_q.delete(); end
    p = ref_model(bus.operand_i);
    if (in_fire) begin exp_q.push_back(p); pc_q.push_back(cyc); accepts++; end
    if (in_fire && p[8]) nv_m = 1'b1;
    else if (bus.clr_status_i) nv_m = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [64:0] op, input bit rdy);
    bus.in_valid_i  = v;
    bus.operand_i   = op;
    bus.out_ready_i = rdy;
  endtask

  initial begin : main
    logic [64:0] dir_ops [4];
    logic [9:0]  dir_cls [4];
    int p0, a0;
    bus.flush_i = 1'b0; bus.clr_status_i = 1'b0;
    drive(1'b0, '0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_class", bus.class_o, 0);
    chk("rst_flags", {bus.sign_o, bus.is_special_o, bus.is_canon_nan_o}, 0);
    chk("rst_nv", bus.status_nv_o, 0);
    chk("rst_in_ready", bus.in_ready_o, 1);
    rst = 1'b0;

    // Four directed classes, back to back with a free consumer
    dir_ops[0] = {1'b1, 64'h7FF0_0000_0000_0000}; dir_cls[0] = 10'h080;
    dir_ops[1] = {1'b1, 64'hFFF0_0000_0000_0000}; dir_cls[1] = 10'h001;
    dir_ops[2] = {1'b1, 64'h0000_0000_0000_0001}; dir_cls[2] = 10'h020;
    dir_ops[3] = {1'b1, 64'h8000_0000_0000_0000}; dir_cls[3] = 10'h008;
    lat_en = 1'b1;
    seen.delete();
    for (int i = 0; i < 4; i++) begin drive(1'b1, dir_ops[i], 1'b1); tick(); end
    drive(1'b0, '0, 1'b1);
    repeat (C_NS + 1) tick();
    chk("dir_count", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) chk($sformatf("dir_class%0d", i), seen[i], dir_cls[i]);

    // Unboxed input reads as canonical NaN
    drive(1'b1, {1'b0, 64'h0123_4567_89AB_CDEF}, 1'b1); tick();
    drive(1'b0, '0, 1'b1); repeat (C_NS + 1) tick();
    chk("unboxed_class", last_out[9:0], 10'h200);
    chk("unboxed_flags", last_out[12:10], 3'b110);

    // Sticky NV: set on sNaN accept, set beats a same-cycle clear
    chk("nv_before", bus.status_nv_o, 0);
    drive(1'b1, {1'b1, 64'h7FF0_0000_0000_0001}, 1'b1); tick();
    chk("nv_set", bus.status_nv_o, 1);
    bus.clr_status_i = 1'b1;
    drive(1'b1, {1'b1, 64'hFFF0_0000_0000_0002}, 1'b1); tick();
    chk("nv_set_wins", bus.status_nv_o, 1);
    drive(1'b0, '0, 1'b1); tick();
    bus.clr_status_i = 1'b0;
    chk("nv_cleared", bus.status_nv_o, 0);
    repeat (C_NS) tick();
    chk("snan_class", seen[seen.size()-1], 10'h100);

    // Backpressure: two accepts fill the pipe, then in_ready drops
    lat_en = 1'b0;
    a0 = accepts;
    drive(1'b1, {1'b1, 64'h3FF0_0000_0000_0000}, 1'b0); tick();
    drive(1'b1, {1'b1, 64'h8000_0000_0000_0000}, 1'b0); tick();
    drive(1'b1, {1'b1, 64'h7FF0_0000_0000_0000}, 1'b0); tick(); tick();
    chk("bp_accepts", accepts - a0, 2);
    chk("bp_in_ready", bus.in_ready_o, 0);
    p0 = pops;
    drive(1'b1, {1'b1, 64'h7FF0_0000_0000_0000}, 1'b1); tick();
    drive(1'b0, '0, 1'b1); tick(); tick();
    chk("bp_drain_rate", pops - p0, 3);

    // Flush drops in-flight entries and the operand offered with it
    drive(1'b1, {1'b1, 64'h4000_0000_0000_0000}, 1'b0); tick(); tick();
    bus.flush_i = 1'b1;
    drive(1'b1, {1'b1, 64'h4010_0000_0000_0000}, 1'b1); tick();
    bus.flush_i = 1'b0;
    chk("flush_out_valid", bus.out_valid_o, 0);
    drive(1'b0, '0, 1'b1); tick();
    chk("flush_no_accept", bus.out_valid_o, 0);

    // Asynchronous reset in mid-stream
    drive(1'b1, {1'b1, 64'h7FF0_0000_0000_0003}, 1'b0); tick();
    drive(1'b1, {1'b1, 64'hC000_0000_0000_0000}, 1'b0); tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid_o, 0);
    chk("mid_rst_payload", {bus.is_canon_nan_o, bus.is_special_o, bus.sign_o, bus.class_o}, 0);
    chk("mid_rst_nv", bus.status_nv_o, 0);
    exp_q.delete(); pc_q.delete();
    held = 1'b0; nv_m = 1'b0; nan_m = '0; inf_m = '0;
    drive(1'b0, '0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_in_ready", bus.in_ready_o, 1);

    // Randomised traffic checked by the scoreboard each cycle
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, rand_op(), $urandom_range(0, 9) < 7);
      bus.clr_status_i = ($urandom_range(0, 31) == 0);
      bus.flush_i      = ($urandom_range(0, 63) == 0);
      tick();
    end
    bus.clr_status_i = 1'b0; bus.flush_i = 1'b0;
    drive(1'b0, '0, 1'b1);
    repeat (C_NS + 2) tick();
    chk("drain_empty", exp_q.size(), 0);

`ifdef FPNEW_CLASSIFY_STATS_EN
    bus.clr_status_i = 1'b1; tick(); bus.clr_status_i = 1'b0;
    for (int i = 0; i < 3; i++) begin drive(1'b1, {1'b1, C_CANON}, 1'b1); tick(); end
    for (int i = 0; i < 2; i++) begin drive(1'b1, {1'b1, 64'hFFF0_0000_0000_0000}, 1'b1); tick(); end
    drive(1'b0, '0, 1'b1); repeat (C_NS + 1) tick();
    chk("stats_nan3", bus.nan_count_o, 3);
    chk("stats_inf2", bus.inf_count_o, 2);
    for (int i = 0; i < 65536; i++) begin drive(1'b1, {1'b1, C_CANON}, 1'b1); tick(); end
    drive(1'b0, '0, 1'b1); repeat (C_NS + 1) tick();
    chk("stats_nan_sat", bus.nan_count_o, 16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
